// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: start/reset/run/done sequencer for a group of cores, with a
// halt-or-budget run end, abort, per-run cycle count and sticky halt record.
module proc_run_ctrl #(
   parameter int NUM_CORES  = 1,
   parameter int RST_CYCLES = 1,
   parameter int MAX_CYCLES = 2,
   parameter int CNT_W      = 16,
   parameter int HALT_ALL   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_CORES-1:0] core_halt,
   output logic                 core_rst,
   output logic                 running,
   output logic                 done,
   output logic                 timeout,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [NUM_CORES-1:0] halt_mask
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;
   state_t state, state_n;
   logic [RW-1:0] rcnt, rcnt_n;
   logic [CNT_W-1:0] cnt_n;
   logic [NUM_CORES-1:0] mask_n, hm;
   logic done_n, to_n, halt;
   assign core_rst = (state == IDLE) || (state == RESET);
   assign running  = (state == RUN);
   always_comb begin
      hm      = halt_mask | core_halt;
      halt    = (HALT_ALL != 0) ? &hm : |hm;
      state_n = state;
      rcnt_n  = rcnt;
      cnt_n   = cycle_count;
      mask_n  = halt_mask;
      done_n  = done;
      to_n    = timeout;
      case (state)
         IDLE, DONE: if (start) begin
            state_n = RESET;
            rcnt_n  = RW'(RST_CYCLES);
            cnt_n   = '0;
            mask_n  = '0;
            done_n  = 1'b0;
            to_n    = 1'b0;
         end
         RESET: begin
            rcnt_n  = rcnt - 1'b1;
            state_n = abort ? IDLE : (rcnt == RW'(1)) ? RUN : RESET;
         end
         RUN: begin
            // every RUN edge counts and accumulates, including the one that leaves RUN
            cnt_n  = cycle_count + 1'b1;
            mask_n = hm;
            if (abort)
               state_n = IDLE;
            else if (halt) begin
               state_n = DONE;
               done_n  = 1'b1;
            end else if (cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
               state_n = DONE;
               to_n    = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         rcnt        <= '0;
         cycle_count <= '0;
         halt_mask   <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_n;
         rcnt        <= rcnt_n;
         cycle_count <= cnt_n;
         halt_mask   <= mask_n;
         done        <= done_n;
         timeout     <= to_n;
      end
   end
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed checks of run control across four parameter sets.
module tb_proc_run_ctrl;
   logic clk = 1'b0, rst;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   // A: defaults
   logic sa, aa, cra, rna, dna, toa;
   logic [0:0] ha, hma;
   logic [15:0] cca;
   proc_run_ctrl dut_a (.clk(clk), .rst(rst), .start(sa), .abort(aa), .core_halt(ha),
      .core_rst(cra), .running(rna), .done(dna), .timeout(toa), .cycle_count(cca), .halt_mask(hma));

   // B: one core, budget 5
   logic sb, ab, crb, rnb, dnb, tob;
   logic [0:0] hb, hmb;
   logic [15:0] ccb;
   proc_run_ctrl #(.MAX_CYCLES(5)) dut_b (.clk(clk), .rst(rst), .start(sb), .abort(ab), .core_halt(hb),
      .core_rst(crb), .running(rnb), .done(dnb), .timeout(tob), .cycle_count(ccb), .halt_mask(hmb));

   // C (all-halt) and D (any-halt): four cores, shared stimulus
   logic sc, ac, crc, rnc, dnc, toc, crd, rnd, dnd, tod;
   logic [3:0] hc, hmc, hmd;
   logic [15:0] ccc, ccd;
   proc_run_ctrl #(.NUM_CORES(4), .RST_CYCLES(3), .MAX_CYCLES(20), .HALT_ALL(1)) dut_c (.clk(clk), .rst(rst),
      .start(sc), .abort(ac), .core_halt(hc), .core_rst(crc), .running(rnc), .done(dnc), .timeout(toc),
      .cycle_count(ccc), .halt_mask(hmc));
   proc_run_ctrl #(.NUM_CORES(4), .RST_CYCLES(3), .MAX_CYCLES(20), .HALT_ALL(0)) dut_d (.clk(clk), .rst(rst),
      .start(sc), .abort(ac), .core_halt(hc), .core_rst(crd), .running(rnd), .done(dnd), .timeout(tod),
      .cycle_count(ccd), .halt_mask(hmd));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; sa = 0; aa = 0; ha = 0; sb = 0; ab = 0; hb = 0; sc = 0; ac = 0; hc = 0;
      #2 rst = 1'b0;
      #1;
      chk("por_core_rst", cra, 1); chk("por_running", rna, 0); chk("por_done", dna, 0);
      chk("por_timeout", toa, 0); chk("por_count", cca, 0); chk("por_mask", hmc, 0);
      tick; tick;
      rst = 1'b1;
      // defaults: one reset cycle, two run cycles, timeout
      sa = 1; tick; sa = 0;
      chk("a_reset_core_rst", cra, 1); chk("a_reset_running", rna, 0);
      tick;
      chk("a_run1_core_rst", cra, 0); chk("a_run1_running", rna, 1); chk("a_run1_count", cca, 0);
      tick;
      chk("a_run2_running", rna, 1); chk("a_run2_count", cca, 1);
      tick;
      chk("a_timeout", toa, 1); chk("a_done", dna, 0); chk("a_count", cca, 2);
      chk("a_done_running", rna, 0); chk("a_done_core_rst", cra, 0);
      aa = 1; tick; aa = 0;
      chk("a_abort_in_done_to", toa, 1); chk("a_abort_in_done_cnt", cca, 2);
      // asynchronous reset mid-run, start held throughout
      sa = 1; tick; tick;
      chk("a_run_before_rst", rna, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_core_rst", cra, 1); chk("async_running", rna, 0); chk("async_count", cca, 0);
      chk("async_timeout", toa, 0); chk("async_done", dna, 0);
      tick;
      chk("rst_low_start_ign", rna, 0); chk("rst_low_core_rst", cra, 1);
      rst = 1'b1; sa = 0;
      tick;
      chk("idle_after_rst", cra, 1); chk("idle_after_rst_run", rna, 0);
      // B: halt in 4th RUN cycle
      sb = 1; tick; sb = 0;
      tick; tick; tick; tick;
      chk("b_run4_count", ccb, 3);
      hb = 1; tick; hb = 0;
      chk("b_halt_done", dnb, 1); chk("b_halt_to", tob, 0); chk("b_halt_cnt", ccb, 4); chk("b_halt_mask", hmb, 1);
      // B: halt before RUN ignored, halt on final budget cycle wins
      sb = 1; tick; sb = 0;
      chk("b_restart_cnt", ccb, 0); chk("b_restart_mask", hmb, 0); chk("b_restart_done", dnb, 0);
      hb = 1; tick; hb = 0;
      chk("b_pre_run_mask", hmb, 0); chk("b_run1_running", rnb, 1);
      repeat (4) tick;
      chk("b_run5_count", ccb, 4); chk("b_run5_running", rnb, 1);
      hb = 1; tick; hb = 0;
      chk("b_tie_done", dnb, 1); chk("b_tie_to", tob, 0); chk("b_tie_cnt", ccb, 5);
      // C/D: cores 0,2,1,3 halt in RUN cycles 2,3,5,7
      sc = 1; tick; sc = 0;
      chk("c_rst1", crc, 1); tick; chk("c_rst2", crc, 1); tick; chk("c_rst3", crc, 1);
      tick;
      chk("c_run1_core_rst", crc, 0); chk("c_run1_running", rnc, 1);
      hc = 4'h0; tick; chk("c_cnt1", ccc, 1);
      hc = 4'h1; tick;
      chk("c_mask_0001", hmc, 4'h1); chk("c_running2", rnc, 1);
      chk("d_done", dnd, 1); chk("d_to", tod, 0); chk("d_cnt", ccd, 2); chk("d_mask", hmd, 4'h1);
      hc = 4'h4; tick; chk("c_mask_0101", hmc, 4'h5);
      hc = 4'h0; tick;
      hc = 4'h2; tick; chk("c_mask_0111", hmc, 4'h7);
      hc = 4'h0; tick; chk("c_not_done6", dnc, 0);
      hc = 4'h8; tick; hc = 4'h0;
      chk("c_done", dnc, 1); chk("c_to", toc, 0); chk("c_cnt", ccc, 7); chk("c_mask_1111", hmc, 4'hf);
      chk("c_running_off", rnc, 0); chk("d_mask_frozen", hmd, 4'h1);
      // abort in RUN cycle 2 beats a simultaneous all-halt
      sc = 1; tick; sc = 0;
      tick; tick; tick; tick;
      ac = 1; hc = 4'hf; tick; ac = 0; hc = 4'h0;
      chk("c_abort_core_rst", crc, 1); chk("c_abort_running", rnc, 0); chk("c_abort_cnt", ccc, 2);
      chk("c_abort_done", dnc, 0); chk("c_abort_to", toc, 0);
      chk("d_abort_done", dnd, 0); chk("d_abort_cnt", ccd, 2);
      tick;
      chk("c_abort_hold_cnt", ccc, 2); chk("c_abort_hold_core_rst", crc, 1);
      // restart with start held: three reset cycles, count restarts
      sc = 1; tick;
      chk("c_re_rst1", crc, 1); chk("c_re_cnt", ccc, 0);
      tick; chk("c_re_rst2", crc, 1);
      tick; chk("c_re_rst3", crc, 1);
      tick; sc = 0;
      chk("c_re_run_core_rst", crc, 0); chk("c_re_running", rnc, 1); chk("c_re_run_cnt", ccc, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
